// File: rtl/rob_commit_queue.sv
// rob_commit_queue: in-order reorder queue between issue allocation and the commit stage.
// Entries are allocated at the tail, completed by ID through writeback, and retired in order from the head.
package rob_pkg;
    localparam int XLEN          = 32;
    localparam int TRANS_ID_BITS = 3;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;
endpackage

module rob_commit_queue
    import rob_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = 2**TRANS_ID_BITS,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned NR_WB_PORTS     = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         flush_i,
    input  logic                                         issue_valid_i,
    input  scoreboard_entry_t                            issue_instr_i,
    output logic                                         issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]             wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]                 wb_ex_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]      commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i,
    output logic                                         empty_o
);
    localparam int IW = TRANS_ID_BITS;
    localparam int CW = TRANS_ID_BITS + 1;

    logic [NR_ENTRIES-1:0] alloc_q, done_q;
    scoreboard_entry_t     mem_q [NR_ENTRIES];
    logic [IW-1:0]         head_q, tail_q;
    logic [CW-1:0]         cnt_q, n_ret;
    logic [IW-1:0]         ptr [NR_COMMIT_PORTS];
    logic [NR_COMMIT_PORTS-1:0] ret;
    logic                  issue_fire, chain;
    scoreboard_entry_t     issue_entry;

    always_comb begin
        issue_ready_o    = cnt_q != CW'(NR_ENTRIES);
        issue_trans_id_o = tail_q;
        empty_o          = cnt_q == '0;
        issue_fire       = issue_valid_i & issue_ready_o;
        issue_entry          = issue_instr_i;
        issue_entry.trans_id = tail_q;
        issue_entry.valid    = 1'b0;
        n_ret = '0;
        chain = 1'b1;
        // a port retires only if every older port retires in the same cycle
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            ptr[i]                  = head_q + IW'(i);
            commit_instr_o[i]       = alloc_q[ptr[i]] ? mem_q[ptr[i]] : '0;
            commit_instr_o[i].valid = alloc_q[ptr[i]] & done_q[ptr[i]];
            ret[i] = chain & commit_ack_i[i] & commit_instr_o[i].valid;
            chain  = ret[i];
            n_ret  = n_ret + CW'(ret[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NR_ENTRIES; k++) mem_q[k] <= '0;
        end else if (flush_i) begin
            alloc_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NR_ENTRIES; k++) mem_q[k] <= '0;
        end else begin
            // later ports overwrite earlier ones, so the highest index wins a shared ID
            for (int j = 0; j < NR_WB_PORTS; j++) begin
                if (wb_valid_i[j] && alloc_q[wb_trans_id_i[j]] && !done_q[wb_trans_id_i[j]]) begin
                    done_q[wb_trans_id_i[j]]       <= 1'b1;
                    mem_q[wb_trans_id_i[j]].result <= wb_result_i[j];
                    mem_q[wb_trans_id_i[j]].ex     <= wb_ex_i[j].valid ? wb_ex_i[j] : mem_q[wb_trans_id_i[j]].ex;
                end
            end
            if (issue_fire) begin
                alloc_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= issue_instr_i.ex.valid;
                mem_q[tail_q]   <= issue_entry;
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (ret[i]) begin
                    alloc_q[ptr[i]] <= 1'b0;
                    done_q[ptr[i]]  <= 1'b0;
                    mem_q[ptr[i]]   <= '0;
                end
            end
            tail_q <= tail_q + IW'(issue_fire);
            head_q <= head_q + n_ret[IW-1:0];
            cnt_q  <= cnt_q + CW'(issue_fire) - n_ret;
        end
    end
endmodule

// File: tb/tb_rob_commit_queue.sv
// tb_rob_commit_queue: scoreboard bench for the reorder commit queue.
module tb_rob_commit_queue;
    import rob_pkg::*;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] pc;
        logic [31:0] res;
    } sb_t;

    logic                   clk = 0;
    logic                   rst_ni = 0;
    logic                   flush_i = 0;
    logic                   issue_valid_i = 0;
    scoreboard_entry_t      issue_instr_i = '0;
    logic                   issue_ready_o;
    logic [2:0]             issue_trans_id_o;
    logic [3:0]             wb_valid_i = '0;
    logic [3:0][2:0]        wb_trans_id_i = '0;
    logic [3:0][31:0]       wb_result_i = '0;
    exception_t [3:0]       wb_ex_i = '0;
    scoreboard_entry_t [1:0] commit_instr_o;
    logic [1:0]             commit_ack_i = '0;
    logic                   empty_o;

    sb_t        sb [$];
    logic [2:0] mdl_tail = '0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         issued;

    rob_commit_queue dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_instr_i    (issue_instr_i),
        .issue_ready_o    (issue_ready_o),
        .issue_trans_id_o (issue_trans_id_o),
        .wb_valid_i       (wb_valid_i),
        .wb_trans_id_i    (wb_trans_id_i),
        .wb_result_i      (wb_result_i),
        .wb_ex_i          (wb_ex_i),
        .commit_instr_o   (commit_instr_o),
        .commit_ack_i     (commit_ack_i),
        .empty_o          (empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic ex);
        chk("issue_ready", 64'(issue_ready_o), 64'(1));
        chk("issue_id", 64'(issue_trans_id_o), 64'(mdl_tail));
        issue_instr_i          = '0;
        issue_instr_i.pc       = pc;
        issue_instr_i.trans_id = 3'h7 ^ mdl_tail;
        issue_instr_i.result   = ex ? res : 32'h0;
        issue_instr_i.ex.valid = ex;
        issue_instr_i.ex.cause = ex ? 32'd5 : 32'd0;
        issue_valid_i = 1'b1;
        sb.push_back('{mdl_tail, pc, res});
        mdl_tail++;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic wb(input int j, input logic [2:0] id, input logic [31:0] res);
        wb_valid_i[j]    = 1'b1;
        wb_trans_id_i[j] = id;
        wb_result_i[j]   = res;
        tick();
        wb_valid_i = '0;
    endtask

    task automatic ack(input logic [1:0] mask, input int n);
        sb_t e;
        commit_ack_i = mask;
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            chk("commit_valid", 64'(commit_instr_o[i].valid), 64'(1));
            chk("commit_id", 64'(commit_instr_o[i].trans_id), 64'(e.id));
            chk("commit_pc", 64'(commit_instr_o[i].pc), 64'(e.pc));
            chk("commit_result", 64'(commit_instr_o[i].result), 64'(e.res));
        end
        tick();
        commit_ack_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) rst_ni = 1'b1;
        tick();
        chk("rst_ready", 64'(issue_ready_o), 64'(1));
        chk("rst_id", 64'(issue_trans_id_o), 64'(0));
        chk("rst_empty", 64'(empty_o), 64'(1));
        chk("rst_commit_zero", 64'(commit_instr_o == '0), 64'(1));

        // fill, stall, then retire and issue together while full
        for (int k = 0; k < 8; k++) issue(32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0);
        chk("full_ready", 64'(issue_ready_o), 64'(0));
        issue_valid_i = 1'b1;
        tick();
        chk("full_ignore_id", 64'(issue_trans_id_o), 64'(0));
        chk("full_not_empty", 64'(empty_o), 64'(0));
        wb(0, sb[0].id, sb[0].res);
        ack(2'b01, 1);
        issue_valid_i = 1'b0;
        chk("full_ack_ready", 64'(issue_ready_o), 64'(1));
        chk("wrap_id", 64'(issue_trans_id_o), 64'(0));
        issued = 8;
        while (issued < 20) begin
            issue(32'h300 + 32'(4 * issued), 32'h2000 + 32'(issued), 1'b0);
            issued++;
            wb($urandom_range(0, 3), sb[0].id, sb[0].res);
            ack(2'b01, 1);
        end
        while (sb.size() > 0) begin
            wb($urandom_range(0, 3), sb[0].id, sb[0].res);
            ack(2'b11, 1);
        end
        chk("wrap_empty", 64'(empty_o), 64'(1));
        chk("wrap_tail", 64'(issue_trans_id_o), 64'(4));

        // out-of-order writeback
        issue(32'h400, 32'hA, 1'b0);
        issue(32'h404, 32'hB, 1'b0);
        issue(32'h408, 32'hC, 1'b0);
        wb(1, sb[2].id, 32'hC);
        chk("ooo_wait2", 64'(commit_instr_o[0].valid), 64'(0));
        wb(2, sb[1].id, 32'hB);
        chk("ooo_wait1", 64'(commit_instr_o[0].valid), 64'(0));
        wb_valid_i[0] = 1'b1;
        wb_trans_id_i[0] = sb[0].id;
        wb_result_i[0] = 32'hA;
        #1;
        chk("ooo_same_cycle", 64'(commit_instr_o[0].valid), 64'(0));
        tick();
        wb_valid_i = '0;
        chk("ooo_visible", 64'(commit_instr_o[0].valid), 64'(1));
        ack(2'b11, 2);
        ack(2'b11, 1);
        chk("ooo_empty", 64'(empty_o), 64'(1));

        // ack gating rules
        issue(32'h500, 32'h51, 1'b0);
        issue(32'h504, 32'h52, 1'b0);
        wb(3, sb[0].id, sb[0].res);
        ack(2'b11, 1);
        chk("ack11_head", 64'(commit_instr_o[0].trans_id), 64'(sb[0].id));
        chk("ack11_pending", 64'(commit_instr_o[0].valid), 64'(0));
        wb(0, sb[0].id, sb[0].res);
        issue(32'h508, 32'h53, 1'b0);
        wb(1, sb[1].id, sb[1].res);
        ack(2'b10, 0);
        chk("ack10_head", 64'(commit_instr_o[0].trans_id), 64'(sb[0].id));
        chk("ack10_valid", 64'(commit_instr_o[1].valid), 64'(1));
        ack(2'b11, 2);
        chk("ack_empty", 64'(empty_o), 64'(1));

        // flush beats issue, writeback and ack in the same cycle
        for (int k = 0; k < 5; k++) issue(32'h600 + 32'(4 * k), 32'h60 + 32'(k), 1'b0);
        wb(0, sb[0].id, sb[0].res);
        issue_valid_i = 1'b1;
        wb_valid_i[1] = 1'b1;
        wb_trans_id_i[1] = sb[1].id;
        commit_ack_i = 2'b01;
        flush_i = 1'b1;
        tick();
        {issue_valid_i, flush_i} = '0;
        wb_valid_i = '0;
        commit_ack_i = '0;
        sb.delete();
        mdl_tail = '0;
        chk("flush_empty", 64'(empty_o), 64'(1));
        chk("flush_id", 64'(issue_trans_id_o), 64'(0));
        chk("flush_ready", 64'(issue_ready_o), 64'(1));
        chk("flush_commit_zero", 64'(commit_instr_o == '0), 64'(1));

        // exception at issue, writeback conflict, stray writeback
        issue(32'h700, 32'h0E0E, 1'b1);
        chk("ex_valid", 64'(commit_instr_o[0].valid), 64'(1));
        chk("ex_flag", 64'(commit_instr_o[0].ex.valid), 64'(1));
        issue(32'h704, 32'h333, 1'b0);
        issue(32'h708, 32'h77, 1'b0);
        wb_valid_i = 4'b1001;
        wb_trans_id_i[0] = 3'd1;
        wb_trans_id_i[3] = 3'd1;
        wb_result_i[0] = 32'h111;
        wb_result_i[3] = 32'h333;
        tick();
        wb_valid_i = '0;
        chk("wb_conflict", 64'(commit_instr_o[1].result), 64'h333);
        wb(2, 3'd5, 32'h555);
        chk("stray_id", 64'(issue_trans_id_o), 64'(3));
        chk("stray_commit1", 64'(commit_instr_o[1].result), 64'h333);
        chk("stray_empty", 64'(empty_o), 64'(0));
        ack(2'b11, 2);
        chk("head_pending", 64'(commit_instr_o[0].valid), 64'(0));
        wb(0, sb[0].id, sb[0].res);
        ack(2'b01, 1);
        chk("final_empty", 64'(empty_o), 64'(1));

        // asynchronous reset mid-operation
        issue(32'h800, 32'h1, 1'b0);
        issue(32'h804, 32'h2, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_empty", 64'(empty_o), 64'(1));
        chk("arst_id", 64'(issue_trans_id_o), 64'(0));
        chk("arst_commit_zero", 64'(commit_instr_o == '0), 64'(1));
        @(negedge clk) rst_ni = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
